// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle shifter: FSM states, shift modes,
// direction encoding and default operand / amount widths.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LOGIC = 2'b00;
  localparam mode_t MODE_ARITH = 2'b01;
  localparam mode_t MODE_ROT   = 2'b10;
  localparam mode_t MODE_RSVD  = 2'b11;  // behaves as MODE_LOGIC

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic state_busy(input state_t st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request / completion bundle between a requester and shift_seq.
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) ();

  // start is a request pulse taken only while busy is low; operand, amount,
  // dir and mode are captured on that same edge and ignored afterwards.
  // busy stays high until the operation retires, done pulses for exactly one
  // cycle at the end, and result is reloaded on the edge closing that cycle.
  logic             start;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             dir;
  mode_t            mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, operand, amount, dir, mode,
    input  busy, done, result
  );

  modport slave (
    input  start, operand, amount, dir, mode,
    output busy, done, result
  );

endinterface

// File: rtl/shift_seq_step.sv
// Single 1-bit shift/rotate step, purely combinational.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in_word,
  input  logic             dir,
  input  mode_t            mode,
  output logic [WIDTH-1:0] out_word
);

  logic fill;

  always_comb begin
    fill     = 1'b0;
    out_word = in_word;
    if (dir == DIR_RIGHT) begin
      case (mode)
        MODE_ARITH: fill = in_word[WIDTH-1];
        MODE_ROT:   fill = in_word[0];
        default:    fill = 1'b0;
      endcase
      out_word = {fill, in_word[WIDTH-1:1]};
    end else begin
      // Arithmetic left is the same as logical left: zero into bit 0.
      fill     = (mode == MODE_ROT) ? in_word[WIDTH-1] : 1'b0;
      out_word = {in_word[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter: captures a request, performs one 1-bit step per cycle
// for the requested count, then publishes the result with a done pulse.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic         clk,
  input  logic         rst_b,
  shift_seq_if.slave   bus,
  output state_t       state_dbg
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] work_q;
  logic [AMT_W-1:0] count_q;
  logic             dir_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] step_out;

  logic accept;
  logic step_en;
  logic load_result;
  logic busy;
  logic done;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .in_word  (work_q),
    .dir      (dir_q),
    .mode     (mode_q),
    .out_word (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // The step on this edge is the last one when one remains.
        if (count_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    step_en     = 1'b0;
    load_result = 1'b0;
    busy        = state_busy(state_q);
    done        = 1'b0;
    case (state_q)
      ST_IDLE:  accept = bus.start;
      ST_SHIFT: step_en = 1'b1;
      ST_DONE: begin
        load_result = 1'b1;
        done        = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured once; later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      work_q   <= '0;
      count_q  <= '0;
      dir_q    <= DIR_LEFT;
      mode_q   <= MODE_LOGIC;
      result_q <= '0;
    end else begin
      if (accept) begin
        work_q  <= bus.operand;
        count_q <= bus.amount;
        dir_q   <= bus.dir;
        mode_q  <= bus.mode;
      end
      if (step_en) begin
        work_q  <= step_out;
        count_q <= count_q - AMT_W'(1);
      end
      if (load_result) begin
        result_q <= work_q;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed-vector bench for shift_seq: hand-computed results, latency,
// busy/done timing, ignored requests while busy, and reset behaviour.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic   clk = 1'b0;
  logic   rst_b;
  state_t state_dbg;

  shift_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_seq #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int               n_vec  = 0;
  int               n_miss = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_result;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start   = 1'b0;
    bus.operand = '0;
    bus.amount  = '0;
    bus.dir     = DIR_LEFT;
    bus.mode    = MODE_LOGIC;
  endtask

  task automatic drive_junk();
    bus.start   = 1'($urandom_range(0, 1));
    bus.operand = 16'($urandom_range(0, 65535));
    bus.amount  = 4'($urandom_range(0, 15));
    bus.dir     = 1'($urandom_range(0, 1));
    bus.mode    = 2'($urandom_range(0, 3));
  endtask

  // One request; expected done one cycle after the last step (N+1 cycles
  // after the accepting edge), busy throughout, result frozen until after done.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] op,
                        input logic [AMT_W-1:0] amt, input logic d,
                        input logic [1:0] m, input logic [WIDTH-1:0] exp);
    int n;
    int done_at;
    int busy_low;
    int res_moves;
    n         = int'(amt);
    done_at   = -1;
    busy_low  = 0;
    res_moves = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.operand = op;
    bus.amount  = amt;
    bus.dir     = d;
    bus.mode    = m;
    @(posedge clk);
    for (int k = 1; k <= n + 4 && done_at < 0; k++) begin
      @(negedge clk);
      if (!bus.busy && k <= n + 1) busy_low++;
      if (bus.result !== last_result) res_moves++;
      if (bus.done) begin
        done_at   = k;
        bus.start = 1'b0;
      end else if (k <= n) begin
        drive_junk();
      end else begin
        bus.start = 1'b0;
      end
    end
    check({tag, " done latency"}, 32'(done_at), 32'(n + 1));
    check({tag, " busy gaps"}, 32'(busy_low), 32'd0);
    check({tag, " result moved early"}, 32'(res_moves), 32'd0);
    @(negedge clk);
    check({tag, " done width"}, 32'(bus.done), 32'd0);
    check({tag, " busy after"}, 32'(bus.busy), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(exp_q.pop_front()));
    last_result = exp;
    drive_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_seen;
    drive_idle();
    rst_b       = 1'b1;
    last_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset state", 32'(state_dbg), 32'(ST_IDLE));
    rst_b = 1'b0;

    run_op("lsl3 B76B",      16'hB76B, 4'd3,  DIR_LEFT,  MODE_LOGIC, 16'hBB58);
    run_op("asr4 8000",      16'h8000, 4'd4,  DIR_RIGHT, MODE_ARITH, 16'hF800);
    run_op("lsr4 8000",      16'h8000, 4'd4,  DIR_RIGHT, MODE_LOGIC, 16'h0800);
    run_op("rsvd lsr4 8000", 16'h8000, 4'd4,  DIR_RIGHT, MODE_RSVD,  16'h0800);
    run_op("rol1 8001",      16'h8001, 4'd1,  DIR_LEFT,  MODE_ROT,   16'h0003);
    run_op("ror1 8001",      16'h8001, 4'd1,  DIR_RIGHT, MODE_ROT,   16'hC000);
    run_op("amt0 1234",      16'h1234, 4'd0,  DIR_LEFT,  MODE_LOGIC, 16'h1234);
    run_op("lsr15 FFFF",     16'hFFFF, 4'd15, DIR_RIGHT, MODE_LOGIC, 16'h0001);
    run_op("asl1 4001",      16'h4001, 4'd1,  DIR_LEFT,  MODE_ARITH, 16'h8002);
    run_op("ror15 0001",     16'h0001, 4'd15, DIR_RIGHT, MODE_ROT,   16'h0002);
    run_op("asr15 7FFF",     16'h7FFF, 4'd15, DIR_RIGHT, MODE_ARITH, 16'h0000);
    run_op("rol15 B76B",     16'hB76B, 4'd15, DIR_LEFT,  MODE_ROT,   16'hDBB5);

    // Abort mid-operation: second start ignored, reset clears without done.
    done_seen = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.operand = 16'hB76B;
    bus.amount  = 4'd8;
    bus.dir     = DIR_LEFT;
    bus.mode    = MODE_LOGIC;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus.done) done_seen++;
      case (c)
        1: bus.start = 1'b0;
        2: begin
          bus.start   = 1'b1;
          bus.operand = 16'hFFFF;
          bus.amount  = 4'd1;
        end
        3: begin
          check("abort busy before reset", 32'(bus.busy), 32'd1);
          bus.start = 1'b0;
        end
        default: rst_b = 1'b1;
      endcase
    end
    @(negedge clk);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort result", 32'(bus.result), 32'd0);
    check("abort state", 32'(state_dbg), 32'(ST_IDLE));
    rst_b = 1'b0;
    drive_idle();
    last_result = '0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort done pulses", 32'(done_seen), 32'd0);

    // Reset and start on the same edge: reset wins.
    done_seen = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.operand = 16'h1234;
    bus.amount  = 4'd0;
    rst_b       = 1'b1;
    @(negedge clk);
    check("rst+start busy", 32'(bus.busy), 32'd0);
    check("rst+start done", 32'(bus.done), 32'd0);
    check("rst+start state", 32'(state_dbg), 32'(ST_IDLE));
    rst_b = 1'b0;
    drive_idle();
    repeat (5) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("rst+start done pulses", 32'(done_seen), 32'd0);
    check("rst+start result", 32'(bus.result), 32'd0);

    run_op("recover lsl4 00F0", 16'h00F0, 4'd4, DIR_LEFT, MODE_LOGIC, 16'h0F00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter AMT_W, default 4, shift-amount width; max shift = 2^AMT_W-1.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk and rst_b are the only clock and reset ports, as the line below states.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 rst_b  input  1  synchronous reset, active-high (asserted = 1).
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 operand  input  WIDTH  value to shift; captured on accepted start.
REQ-008 amount  input  AMT_W  number of 1-bit steps; captured on accepted start.
REQ-009 dir  input  1  1 = right shift, 0 = left shift; captured on accepted start.
REQ-010 mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 treated as logical; captured on accepted start.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when result becomes valid.
REQ-013 result  output  WIDTH  registered final value; held until next accepted start completes.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE: start=1 accepts; working reg <= operand, count <= amount, dir/mode latched; next = SHIFT if amount != 0, else DONE.
REQ-016 SHIFT: each cycle perform exactly one 1-bit step on working reg, count <= count-1; when count == 1 next = DONE.
REQ-017 DONE: result <= working reg, done = 1 for this single cycle, next = IDLE.
REQ-018 Latency: start accepted at cycle t -> done high at cycle t+N+1 for amount N >= 1; t+1 for N = 0.
REQ-019 Left step: bit0 fill = 0 (logical/arith), = old MSB (rotate).
REQ-020 Right step: MSB fill = 0 (logical), = old MSB (arith), = old bit0 (rotate).
REQ-021 start while busy SHALL be ignored; no queuing; inputs changing while busy have no effect.
REQ-022 Next start is accepted no earlier than the cycle after DONE (back-to-back throughput = N+2 cycles).
REQ-023 Shifts of amount >= WIDTH (only when AMT_W widened) SHALL still step N times (logical result 0, arith result all sign).
REQ-024 result SHALL change only in DONE; it is stable during SHIFT.

Reset
REQ-025 rst_b = 1 SHALL force state IDLE, busy 0, done 0, result 0, working reg 0, count 0 on the same posedge.
REQ-026 Reset mid-operation SHALL abort without asserting done; reset wins over a simultaneous start.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (IDLE/SHIFT/DONE), mode encodings, and default WIDTH/AMT_W.
REQ-028 One sub-module, shift_step (combinational 1-bit step: in, dir, mode -> out), SHALL be instantiated once; the FSM, counter and registers stay in shift_seq.

Verification
REQ-029 operand 0xB76B, amount 3, dir 0, mode 00 -> result 0xBB58, done at t+4, busy high for t+1..t+4.
REQ-030 operand 0x8000, amount 4, dir 1: mode 01 -> 0xF800; mode 00 -> 0x0800.
REQ-031 operand 0x8001, amount 1, dir 0, mode 10 -> 0x0003; dir 1, mode 10 -> 0xC000.
REQ-032 operand 0x1234, amount 0 -> result 0x1234, done at t+1; amount 15, dir 1, mode 00, operand 0xFFFF -> 0x0001, done at t+16.
REQ-033 start 0xB76B amount 8, second start at t+2 (ignored), rst_b=1 at t+4 -> busy 0, result 0x0000, no done pulse.
REQ-034 start and rst_b asserted in the same cycle -> remains IDLE, busy 0, no done.
